// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
//   Bundles the pipeline cache ports and the RAM model port of the single-port
//   RAM arbiter.
//   slave  : arbiter view (requests and RAM response in, grants/data/stalls out)
//   master : environment view (pipeline requesters plus the RAM model)
//   I-side  : iREN, iaddr -> iload, iwait
//   D-side  : dREN, dWEN, daddr, dstore -> dload, dwait
//   RAM     : ramREN, ramWEN, ramaddr, ramstore -> ramload, ramstate
//   ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              iwait;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dwait;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port RAM between the fetch stage (I-side) and the MEM
//   stage (D-side). Registered grant FSM, D-side wins by default; each side
//   sees a stall (iwait/dwait) until its transfer completes.
//   Ports:
//     clk_i     : clock, rising edge
//     rst_i     : synchronous active-high reset
//     bus       : ram_arbiter_if.slave (requesters and RAM model)
//     arb_err_o : sticky error flag (RAM ERROR or grant timeout), cleared by reset
//   Optional feature: define RAM_ARB_STARVE_EN to let the I-side in after
//   MAX_DGRANTS consecutive D-completions while iREN is pending.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | no grant, RAM outputs 0, picks next requester
//   IGNT  | I-side owns the RAM, waiting for ACCESS
//   DGNT  | D-side owns the RAM, waiting for ACCESS
module ram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter int MAX_DGRANTS = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ram_arbiter_if.slave  bus,
    output logic          arb_err_o
);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;
    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             d_req;
    logic             tmo_hit;
    logic             starve_full;

    assign d_req     = bus.dREN | bus.dWEN;
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT));
    assign arb_err_o = err_q;

    always_comb begin
        state_d      = state_q;
        tmo_d        = '0;
        err_d        = err_q;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = ADDR_ZERO;
        bus.ramstore = DATA_ZERO;
        bus.iload    = DATA_ZERO;
        bus.dload    = DATA_ZERO;
        bus.iwait    = bus.iREN;
        bus.dwait    = d_req;

        unique case (state_q)
            IDLE: begin
                if (d_req && !(starve_full && bus.iREN)) state_d = DGNT;
                else if (bus.iREN)                      state_d = IGNT;
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!d_req) begin
                    // requester withdrew: abandon without completion
                    state_d = IDLE;
                end else if (bus.ramstate == RS_ACCESS) begin
                    bus.dwait = 1'b0;
                    bus.dload = bus.ramload;
                    state_d   = IDLE;
                end else if (bus.ramstate == RS_ERROR || tmo_hit) begin
                    bus.dwait = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = 1'b1;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (bus.ramstate == RS_ACCESS) begin
                    bus.iwait = 1'b0;
                    bus.iload = bus.ramload;
                    state_d   = IDLE;
                end else if (bus.ramstate == RS_ERROR || tmo_hit) begin
                    bus.iwait = 1'b0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // reset overrides everything the FSM would drive this cycle
        if (rst_i) begin
            bus.ramREN   = 1'b0;
            bus.ramWEN   = 1'b0;
            bus.ramaddr  = ADDR_ZERO;
            bus.ramstore = DATA_ZERO;
            bus.iload    = DATA_ZERO;
            bus.dload    = DATA_ZERO;
            bus.iwait    = bus.iREN;
            bus.dwait    = d_req;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

`ifdef RAM_ARB_STARVE_EN
    localparam int SC_W = (MAX_DGRANTS < 2) ? 1 : $clog2(MAX_DGRANTS + 1);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            d_done;

    // a D completion is the only DGNT cycle with dwait low while requesting
    assign d_done      = (state_q == DGNT) && d_req && !bus.dwait;
    assign starve_full = (starve_q == SC_W'(MAX_DGRANTS));

    always_comb begin
        starve_d = starve_q;
        if (!bus.iREN || state_q == IGNT) starve_d = '0;
        else if (d_done && !starve_full)  starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) starve_q <= '0;
        else       starve_q <= starve_d;
    end
`else
    // strict D priority; MAX_DGRANTS only matters with the guard compiled in
    assign starve_full = (MAX_DGRANTS < 0);
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic clk = 1'b0;
    logic rst;
    logic arb_err;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .MAX_DGRANTS(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .arb_err_o(arb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0;
        bus.ramstate = FREE; bus.ramload = 32'h0;
    endtask

    // random-phase reference state
    logic [31:0] ram_mem [16];
    logic [31:0] ref_mem [16];

    initial begin
        int d_before, i_done, tw;
        bit i_seen, dropped;
        bit i_busy, d_busy, lat_act;
        int lat, i_age, d_age, max_i_age, max_d_age, n_idone, n_ddone;

        rst = 1; bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0;
        idle_inputs();
        bus.iREN = 1;

        // ---- reset held two cycles with iREN high
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("rst_ramREN", bus.ramREN, 0);
            chk("rst_iwait", bus.iwait, 1);
            chk("rst_arb_err", arb_err, 0);
            chk("rst_ramaddr", bus.ramaddr, 0);
        end

        // ---- I-read at 0x40, ACCESS on third grant cycle
        @(negedge clk); rst = 0; bus.iaddr = 32'h40; #1;
        chk("iread_idle_ramREN", bus.ramREN, 0);
        chk("iread_idle_iwait", bus.iwait, 1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); bus.ramstate = BUSY; #1;
            chk("iread_ramaddr", bus.ramaddr, 32'h40);
            chk("iread_ramREN", bus.ramREN, 1);
            chk("iread_iwait_busy", bus.iwait, 1);
            chk("iread_iload_busy", bus.iload, 0);
        end
        @(negedge clk); bus.ramstate = ACCESS; bus.ramload = 32'h8C220004; #1;
        chk("iread_iwait_done", bus.iwait, 0);
        chk("iread_iload", bus.iload, 32'h8C220004);
        @(negedge clk); idle_inputs(); #1;
        chk("iread_back_idle", bus.ramREN, 0);
        chk("iread_iload_zero", bus.iload, 0);

        // ---- collision: D write wins, then I read
        @(negedge clk);
        bus.iREN = 1; bus.iaddr = 32'h44;
        bus.dWEN = 1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; #1;
        chk("col_idle_dwait", bus.dwait, 1);
        chk("col_idle_iwait", bus.iwait, 1);
        @(negedge clk); bus.ramstate = ACCESS; #1;
        chk("col_d_ramWEN", bus.ramWEN, 1);
        chk("col_d_ramREN", bus.ramREN, 0);
        chk("col_d_ramstore", bus.ramstore, 32'hDEADBEEF);
        chk("col_d_ramaddr", bus.ramaddr, 32'h100);
        chk("col_d_dwait", bus.dwait, 0);
        chk("col_d_iwait", bus.iwait, 1);
        @(negedge clk); bus.dWEN = 0; bus.ramstate = FREE; #1;
        chk("col_gap_ramREN", bus.ramREN, 0);
        @(negedge clk); bus.ramstate = ACCESS; bus.ramload = 32'h1234; #1;
        chk("col_i_ramaddr", bus.ramaddr, 32'h44);
        chk("col_i_ramREN", bus.ramREN, 1);
        chk("col_i_iwait", bus.iwait, 0);
        chk("col_i_iload", bus.iload, 32'h1234);
        @(negedge clk); idle_inputs();

        // ---- starvation: continuous dREN with iREN pending, RAM always ready
        @(negedge clk);
        bus.iREN = 1; bus.iaddr = 32'h80; bus.dREN = 1; bus.daddr = 32'h200;
        bus.ramstate = ACCESS; bus.ramload = 32'h55;
        d_before = 0; i_done = 0; i_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (!bus.iwait) begin i_seen = 1; i_done++; end
            if (!i_seen && !bus.dwait) d_before++;
        end
`ifdef RAM_ARB_STARVE_EN
        chk("starve_d_before_i", d_before, 4);
        chk("starve_i_granted", i_done >= 1, 1);
`else
        chk("strict_d_count", d_before, 10);
        chk("strict_no_i", i_done, 0);
`endif
        @(negedge clk); idle_inputs();
        @(negedge clk);

        // ---- RAM ERROR during DGNT
        @(negedge clk); bus.dREN = 1; bus.daddr = 32'h300; #1;
        chk("err_idle_dwait", bus.dwait, 1);
        @(negedge clk); bus.ramstate = ERROR; bus.ramload = 32'hFFFF; #1;
        chk("err_dwait", bus.dwait, 0);
        chk("err_dload", bus.dload, 0);
        chk("err_ramREN", bus.ramREN, 1);
        @(negedge clk); idle_inputs(); #1;
        chk("err_flag", arb_err, 1);
        @(negedge clk); #1;
        chk("err_flag_sticky", arb_err, 1);

        // ---- timeout: RAM stuck BUSY in IGNT
        @(negedge clk); bus.iREN = 1; bus.iaddr = 32'h60; #1;
        chk("tmo_idle_iwait", bus.iwait, 1);
        tw = 0; dropped = 0;
        for (int c = 0; c < 20 && !dropped; c++) begin
            @(negedge clk); bus.ramstate = BUSY; bus.ramload = 32'hABCD; #1;
            if (bus.iwait) tw++;
            else begin
                dropped = 1;
                chk("tmo_iload", bus.iload, 0);
                chk("tmo_ramREN", bus.ramREN, 1);
            end
        end
        chk("tmo_wait_cycles", tw, 8);
        chk("tmo_dropped", dropped, 1);
        @(negedge clk); idle_inputs(); #1;
        chk("tmo_flag", arb_err, 1);

        // ---- reset asserted mid-DGNT
        @(negedge clk); bus.dREN = 1; bus.daddr = 32'h300;
        @(negedge clk); rst = 1; bus.ramstate = BUSY; #1;
        chk("mrst_ramREN", bus.ramREN, 0);
        chk("mrst_ramaddr", bus.ramaddr, 0);
        chk("mrst_dwait", bus.dwait, 1);
        chk("mrst_dload", bus.dload, 0);
        @(negedge clk); rst = 0; bus.ramstate = ACCESS; #1;
        chk("mrst_idle_ramREN", bus.ramREN, 0);
        chk("mrst_idle_dwait", bus.dwait, 1);
        chk("mrst_err_clear", arb_err, 0);
        @(negedge clk); idle_inputs();
        @(negedge clk);

        // ---- requester withdraws mid-DGNT
        @(negedge clk); bus.dREN = 1; bus.daddr = 32'h310;
        @(negedge clk); bus.dREN = 0; bus.ramstate = BUSY; #1;
        chk("abort_dload", bus.dload, 0);
        chk("abort_ramREN", bus.ramREN, 0);
        @(negedge clk); bus.dWEN = 1; bus.ramstate = ACCESS; #1;
        chk("abort_idle_ramWEN", bus.ramWEN, 0);
        chk("abort_idle_dwait", bus.dwait, 1);
        chk("abort_no_err", arb_err, 0);
        @(negedge clk); idle_inputs();
        @(negedge clk);

        // ---- randomized traffic against a word-memory reference
        for (int k = 0; k < 16; k++) begin
            ram_mem[k] = $urandom;
            ref_mem[k] = ram_mem[k];
        end
        i_busy = 0; d_busy = 0; lat_act = 0; lat = 0;
        i_age = 0; d_age = 0; max_i_age = 0; max_d_age = 0; n_idone = 0; n_ddone = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!i_busy) begin
                bus.iREN = 0;
                if ($urandom_range(0, 2) == 0) begin
                    i_busy = 1; i_age = 0;
                    bus.iREN = 1; bus.iaddr = $urandom_range(0, 15);
                end
            end
            if (!d_busy) begin
                bus.dREN = 0; bus.dWEN = 0;
                if ($urandom_range(0, 2) == 0) begin
                    d_busy = 1; d_age = 0;
                    bus.dWEN = $urandom_range(0, 1);
                    bus.dREN = ~bus.dWEN;
                    bus.daddr = $urandom_range(0, 15);
                    bus.dstore = $urandom;
                end
            end
            #1;
            chk("rnd_excl", bus.ramREN & bus.ramWEN, 0);
            if (bus.ramREN || bus.ramWEN) begin
                if (!lat_act) begin lat_act = 1; lat = $urandom_range(0, 3); end
                if (lat == 0) begin
                    bus.ramstate = ACCESS;
                    bus.ramload = ram_mem[bus.ramaddr[3:0]];
                    lat_act = 0;
                end else begin
                    bus.ramstate = BUSY; bus.ramload = $urandom; lat--;
                end
            end else begin
                lat_act = 0; bus.ramstate = FREE; bus.ramload = $urandom;
            end
            #1;
            if (bus.ramWEN && bus.ramstate == ACCESS) ram_mem[bus.ramaddr[3:0]] = bus.ramstore;
            if (i_busy && !bus.iwait) begin
                chk("rnd_iload", bus.iload, ref_mem[bus.iaddr[3:0]]);
                i_busy = 0; n_idone++;
            end else begin
                chk("rnd_iload_zero", bus.iload, 0);
            end
            if (d_busy && !bus.dwait) begin
                if (bus.dWEN) ref_mem[bus.daddr[3:0]] = bus.dstore;
                else chk("rnd_dload", bus.dload, ref_mem[bus.daddr[3:0]]);
                d_busy = 0; n_ddone++;
            end else begin
                chk("rnd_dload_zero", bus.dload, 0);
            end
            if (i_busy) begin i_age++; if (i_age > max_i_age) max_i_age = i_age; end
            if (d_busy) begin d_age++; if (d_age > max_d_age) max_d_age = d_age; end
        end
        chk("rnd_i_latency_bound", max_i_age <= 100, 1);
        chk("rnd_d_latency_bound", max_d_age <= 100, 1);
        chk("rnd_i_progress", n_idone > 20, 1);
        chk("rnd_d_progress", n_ddone > 20, 1);
        chk("rnd_no_err", arb_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
